// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 serial receiver: FSM encoding and bit-timing helpers.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_HIGH = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } rx_state_e;

    function automatic int unsigned calc_bit_cycles(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned calc_half(input int unsigned clk_hz, input int unsigned baud);
        return calc_bit_cycles(clk_hz, baud) / 32'd2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;

    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];
    assign rd_en_s = i_pop && !o_empty;
    assign wr_en_s = i_push && (!o_full || rd_en_s);

    // Pointer, occupancy and storage next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 serial receiver: synchronizer, mid-bit sampling FSM, and FWFT output stream with tlast.
module uart_rx_stream
    import uart_rx_pkg::*;
#(
    parameter int unsigned clk_freq_hz = 50000000,
    parameter int unsigned baud_rate   = 57600,
    parameter int unsigned depth       = 4,
    parameter logic [7:0]  last_char   = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int unsigned BIT_CYCLES = calc_bit_cycles(clk_freq_hz, baud_rate);
    localparam int unsigned HALF       = calc_half(clk_freq_hz, baud_rate);
    localparam int unsigned CW         = $clog2(BIT_CYCLES);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_sync_q;
    logic [1:0]    primed_q, primed_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          rx_s, tick_s, push_s, pop_s, fifo_full_s, fifo_empty_s;
    logic [8:0]    head_s;

    assign rx_s     = rx_sync_q;
    assign tick_s   = (cnt_q == '0);
    assign o_tvalid = !fifo_empty_s;
    assign pop_s    = o_tvalid && i_tready;
    assign o_tdata  = head_s[7:0];
    assign o_tlast  = head_s[8];
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    // The synchronizer resets high, so WAIT_HIGH also waits until it holds real line samples.
    assign primed_d  = {primed_q[0], 1'b1};
    assign overrun_d = push_s && fifo_full_s && !pop_s;

    // Frame sequencing: next state, bit timer, shift register, push and error strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_WAIT_HIGH: begin
                if (rx_s && primed_q[1]) state_d = ST_IDLE;
                else                     state_d = ST_WAIT_HIGH;
            end
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = CW'(HALF - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_DATA;
                    cnt_d     = CW'(BIT_CYCLES - 1);
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = CW'(BIT_CYCLES - 1);
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else                   state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STOP: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    push_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = ST_WAIT_HIGH;
                end
            end
            default: state_d = ST_WAIT_HIGH;
        endcase
    end

    // State, timing and synchronizer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_WAIT_HIGH;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            primed_q    <= 2'b00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_meta_q   <= i_rx;
            rx_sync_q   <= rx_meta_q;
            primed_q    <= primed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (9),
        .DEPTH (depth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_s),
        .i_data  ({(shift_q == last_char), shift_q}),
        .o_full  (fifo_full_s),
        .i_pop   (pop_s),
        .o_empty (fifo_empty_s),
        .o_head  (head_s)
    );

endmodule
